// File: rtl/hand_ctrl_trap_pkg.sv
// Shared constants and helpers for the hand-controller trap block.
// Defaults describe the classic three-group, eight-bit, active-low arrangement.
package hand_ctrl_trap_pkg;

   localparam int   DEF_NGRP    = 3;
   localparam int   DEF_GW      = 8;
   localparam int   DEF_DEB     = 2;
   localparam int   DEF_ACT_LOW = 1;
   localparam logic INACTIVE_LVL = (DEF_ACT_LOW != 0) ? 1'b1 : 1'b0;

   // Smallest width able to hold values 0..n-1; never below one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/trap_debounce_bit.sv
// Single-bit N-sample debouncer with a strobe for a change to the active level.
// The strobe is combinational so the trap logic can act at the same edge.
module trap_debounce_bit
   import hand_ctrl_trap_pkg::*;
#(
   parameter int   DEB   = DEF_DEB,
   parameter logic INACT = INACTIVE_LVL
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic smpl_i,
   input  logic raw_i,
   output logic stable_o,
   output logic act_o
);

   localparam int CW = clog2(DEB + 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          stable_q, stable_d;
   logic          differ, flip;

   always_comb begin
      cnt_inc  = cnt_q + CW'(1);
      differ   = (raw_i != stable_q);
      flip     = smpl_i && differ && (cnt_inc == CW'(DEB));
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (smpl_i) begin
         if (flip) begin
            stable_d = raw_i;
            cnt_d    = '0;
         end else if (differ) begin
            cnt_d = cnt_inc;
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         stable_q <= INACT;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;
   assign act_o    = flip && (raw_i != INACT);

endmodule

// File: rtl/hand_ctrl_trap.sv
// Debounced trap groups with one-shot arms, pending flags and an interrupt pulse.
// A group trapping at the same edge as an arm write always ends disarmed.
module hand_ctrl_trap
   import hand_ctrl_trap_pkg::*;
#(
   parameter int NGRP    = DEF_NGRP,
   parameter int GW      = DEF_GW,
   parameter int DEB     = DEF_DEB,
   parameter int ACT_LOW = DEF_ACT_LOW
) (
   input  logic              CLOCK,
   input  logic              rst,
   input  logic              SMPL,
   input  logic [NGRP*GW-1:0] RAWIN,
   input  logic              ARMWE,
   input  logic [NGRP-1:0]   ARMD,
   input  logic [NGRP-1:0]   ACK,
   output logic [NGRP*GW-1:0] STABLE,
   output logic [NGRP-1:0]   ARMED,
   output logic [NGRP-1:0]   PEND,
   output logic              HNDRPT
);

   localparam logic INACT = ((ACT_LOW != 0) == (DEF_ACT_LOW != 0)) ? INACTIVE_LVL : !INACTIVE_LVL;

   logic [NGRP*GW-1:0] act;
   logic [NGRP-1:0]    evt, trap;
   logic [NGRP-1:0]    armed_q, armed_d, pend_q, pend_d;
   logic               hndrpt_q, hndrpt_d;

   for (genvar b = 0; b < NGRP*GW; b++) begin : g_deb
      trap_debounce_bit #(.DEB(DEB), .INACT(INACT)) u_deb (
         .clk_i   (CLOCK),
         .rst_i   (rst),
         .smpl_i  (SMPL),
         .raw_i   (RAWIN[b]),
         .stable_o(STABLE[b]),
         .act_o   (act[b])
      );
   end

   always_comb begin
      evt = '0;
      for (int g = 0; g < NGRP; g++) begin
         evt[g] = |act[g*GW +: GW];
      end
      trap     = evt & armed_q;
      armed_d  = (ARMWE ? ARMD : armed_q) & ~trap;
      pend_d   = (pend_q & ~ACK) | trap;
      // Only a fresh 0->1 on a pending flag requests an interrupt.
      hndrpt_d = |(trap & ~pend_q);
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         armed_q  <= '0;
         pend_q   <= '0;
         hndrpt_q <= 1'b0;
      end else begin
         armed_q  <= armed_d;
         pend_q   <= pend_d;
         hndrpt_q <= hndrpt_d;
      end
   end

   assign ARMED  = armed_q;
   assign PEND   = pend_q;
   assign HNDRPT = hndrpt_q;

endmodule

// File: tb/tb_hand_ctrl_trap.sv
// Bench for hand_ctrl_trap: directed scenarios plus randomized traffic against a reference model.
module tb_hand_ctrl_trap;

   localparam int NGRP = 3;
   localparam int GW   = 8;
   localparam int DEB  = 2;
   localparam int NB   = NGRP * GW;

   logic            CLOCK = 1'b0;
   logic            rst   = 1'b0;
   logic            SMPL  = 1'b0;
   logic [NB-1:0]   RAWIN = '1;
   logic            ARMWE = 1'b0;
   logic [NGRP-1:0] ARMD  = '0;
   logic [NGRP-1:0] ACK   = '0;
   logic [NB-1:0]   STABLE;
   logic [NGRP-1:0] ARMED, PEND;
   logic            HNDRPT;

   int n_tests = 0;
   int n_fail  = 0;

   hand_ctrl_trap #(.NGRP(NGRP), .GW(GW), .DEB(DEB), .ACT_LOW(1)) dut (
      .CLOCK (CLOCK),
      .rst   (rst),
      .SMPL  (SMPL),
      .RAWIN (RAWIN),
      .ARMWE (ARMWE),
      .ARMD  (ARMD),
      .ACK   (ACK),
      .STABLE(STABLE),
      .ARMED (ARMED),
      .PEND  (PEND),
      .HNDRPT(HNDRPT)
   );

   always #5 CLOCK = ~CLOCK;

   // Reference model: per-bit run length of disagreeing strobes, group-level trap rules.
   logic [NB-1:0]   m_stable;
   int              m_run [NB];
   logic [NGRP-1:0] m_armed, m_pend;
   logic            m_hnd;

   task automatic model_reset();
      m_stable = '1;
      foreach (m_run[b]) m_run[b] = 0;
      m_armed = '0;
      m_pend  = '0;
      m_hnd   = 1'b0;
   endtask

   task automatic model_step();
      logic [NGRP-1:0] ev, old_pend;
      if (rst) begin
         model_reset();
         return;
      end
      ev = '0;
      old_pend = m_pend;
      m_hnd = 1'b0;
      if (SMPL) begin
         for (int b = 0; b < NB; b++) begin
            if (RAWIN[b] !== m_stable[b]) begin
               m_run[b] = m_run[b] + 1;
               if (m_run[b] == DEB) begin
                  m_stable[b] = RAWIN[b];
                  m_run[b] = 0;
                  if (RAWIN[b] == 1'b0) ev[b / GW] = 1'b1;
               end
            end else begin
               m_run[b] = 0;
            end
         end
      end
      ev = ev & m_armed;
      if (ARMWE) m_armed = ARMD;
      m_pend = m_pend & ~ACK;
      for (int g = 0; g < NGRP; g++) begin
         if (ev[g]) begin
            m_armed[g] = 1'b0;
            m_pend[g]  = 1'b1;
            if (!old_pend[g]) m_hnd = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      model_step();
      #1;
   endtask

   task automatic restore_inputs();
      ACK = '1; ARMWE = 1'b1; ARMD = '0; RAWIN = '1; SMPL = 1'b1;
      tick();
      ACK = '0; ARMWE = 1'b0;
      tick();
      SMPL = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      #3;
      n_tests++; if (STABLE !== 24'hFFFFFF) begin n_fail++; $display("FAIL reset_stable got %h exp %h", STABLE, 24'hFFFFFF); end
      n_tests++; if (ARMED !== 3'b000) begin n_fail++; $display("FAIL reset_armed got %b exp 000", ARMED); end
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL reset_pend got %b exp 000", PEND); end
      n_tests++; if (HNDRPT !== 1'b0) begin n_fail++; $display("FAIL reset_hndrpt got %b exp 0", HNDRPT); end
      #9;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_debounce();
      RAWIN[3] = 1'b0; SMPL = 1'b1;
      tick();
      n_tests++; if (STABLE[3] !== 1'b1) begin n_fail++; $display("FAIL deb_first_strobe got %b exp 1", STABLE[3]); end
      tick();
      n_tests++; if (STABLE[3] !== 1'b0) begin n_fail++; $display("FAIL deb_second_strobe got %b exp 0", STABLE[3]); end
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL deb_unarmed_pend got %b exp 000", PEND); end
      RAWIN[5] = 1'b0;
      tick();
      RAWIN[5] = 1'b1;
      tick();
      RAWIN[5] = 1'b0;
      tick();
      SMPL = 1'b0;
      n_tests++; if (STABLE[5] !== 1'b1) begin n_fail++; $display("FAIL deb_glitch got %b exp 1", STABLE[5]); end
      repeat (3) tick();
      n_tests++; if (STABLE[5] !== 1'b1) begin n_fail++; $display("FAIL deb_hold got %b exp 1", STABLE[5]); end
      SMPL = 1'b1;
      tick();
      SMPL = 1'b0;
      n_tests++; if (STABLE[5] !== 1'b0) begin n_fail++; $display("FAIL deb_after_hold got %b exp 0", STABLE[5]); end
      restore_inputs();
      n_tests++; if (STABLE !== 24'hFFFFFF) begin n_fail++; $display("FAIL deb_restore got %h exp %h", STABLE, 24'hFFFFFF); end
   endtask

   task automatic test_armed_trap();
      ARMWE = 1'b1; ARMD = 3'b001;
      tick();
      ARMWE = 1'b0;
      n_tests++; if (ARMED !== 3'b001) begin n_fail++; $display("FAIL arm_write got %b exp 001", ARMED); end
      RAWIN[2] = 1'b0; SMPL = 1'b1;
      tick();
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL trap_early got %b exp 000", PEND); end
      tick();
      SMPL = 1'b0;
      n_tests++; if (PEND !== 3'b001) begin n_fail++; $display("FAIL trap_pend got %b exp 001", PEND); end
      n_tests++; if (ARMED !== 3'b000) begin n_fail++; $display("FAIL trap_disarm got %b exp 000", ARMED); end
      n_tests++; if (HNDRPT !== 1'b1) begin n_fail++; $display("FAIL trap_hndrpt got %b exp 1", HNDRPT); end
      tick();
      n_tests++; if (HNDRPT !== 1'b0) begin n_fail++; $display("FAIL trap_hndrpt_width got %b exp 0", HNDRPT); end
      ACK = 3'b001;
      tick();
      ACK = '0;
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL trap_ack got %b exp 000", PEND); end
      restore_inputs();
   endtask

   task automatic test_unarmed_inactive();
      logic seen;
      seen = 1'b0;
      RAWIN[10] = 1'b0; SMPL = 1'b1;
      repeat (2) begin tick(); seen |= HNDRPT; end
      SMPL = 1'b0; ARMWE = 1'b1; ARMD = 3'b010;
      tick(); seen |= HNDRPT;
      ARMWE = 1'b0;
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL unarmed_not_kept got %b exp 000", PEND); end
      RAWIN[10] = 1'b1; SMPL = 1'b1;
      repeat (2) begin tick(); seen |= HNDRPT; end
      SMPL = 1'b0;
      tick(); seen |= HNDRPT;
      n_tests++; if (STABLE[10] !== 1'b1) begin n_fail++; $display("FAIL inactive_stable got %b exp 1", STABLE[10]); end
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL inactive_pend got %b exp 000", PEND); end
      n_tests++; if (ARMED !== 3'b010) begin n_fail++; $display("FAIL inactive_armed got %b exp 010", ARMED); end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL unarmed_hndrpt got %b exp 0", seen); end
      restore_inputs();
   endtask

   task automatic test_simultaneous();
      ARMWE = 1'b1; ARMD = 3'b111;
      tick();
      ARMWE = 1'b0;
      RAWIN[0] = 1'b0; RAWIN[8] = 1'b0; RAWIN[16] = 1'b0; SMPL = 1'b1;
      tick(); tick();
      SMPL = 1'b0;
      n_tests++; if (PEND !== 3'b111) begin n_fail++; $display("FAIL simul_pend got %b exp 111", PEND); end
      n_tests++; if (ARMED !== 3'b000) begin n_fail++; $display("FAIL simul_armed got %b exp 000", ARMED); end
      n_tests++; if (HNDRPT !== 1'b1) begin n_fail++; $display("FAIL simul_hndrpt got %b exp 1", HNDRPT); end
      ACK = 3'b010;
      tick();
      ACK = '0;
      n_tests++; if (HNDRPT !== 1'b0) begin n_fail++; $display("FAIL simul_single_pulse got %b exp 0", HNDRPT); end
      n_tests++; if (PEND !== 3'b101) begin n_fail++; $display("FAIL simul_ack got %b exp 101", PEND); end
      restore_inputs();
   endtask

   task automatic test_collision();
      ARMWE = 1'b1; ARMD = 3'b100;
      tick();
      ARMWE = 1'b0;
      RAWIN[20] = 1'b0; SMPL = 1'b1;
      tick();
      ARMWE = 1'b1; ARMD = 3'b111; ACK = 3'b100;
      tick();
      ARMWE = 1'b0; ACK = '0; SMPL = 1'b0;
      n_tests++; if (ARMED !== 3'b011) begin n_fail++; $display("FAIL coll_armed got %b exp 011", ARMED); end
      n_tests++; if (PEND !== 3'b100) begin n_fail++; $display("FAIL coll_pend got %b exp 100", PEND); end
      n_tests++; if (HNDRPT !== 1'b1) begin n_fail++; $display("FAIL coll_hndrpt got %b exp 1", HNDRPT); end
      restore_inputs();
   endtask

   task automatic test_back_to_back();
      ARMWE = 1'b1; ARMD = 3'b011;
      tick();
      ARMWE = 1'b0;
      RAWIN[1] = 1'b0; SMPL = 1'b1;
      tick();
      RAWIN[9] = 1'b0;
      tick();
      n_tests++; if (PEND !== 3'b001 || HNDRPT !== 1'b1) begin n_fail++; $display("FAIL b2b_first got pend %b hnd %b exp 001 1", PEND, HNDRPT); end
      tick();
      SMPL = 1'b0;
      n_tests++; if (PEND !== 3'b011 || HNDRPT !== 1'b1) begin n_fail++; $display("FAIL b2b_second got pend %b hnd %b exp 011 1", PEND, HNDRPT); end
      tick();
      n_tests++; if (HNDRPT !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", HNDRPT); end
      restore_inputs();
   endtask

   task automatic test_reset_mid();
      ARMWE = 1'b1; ARMD = 3'b001;
      tick();
      ARMWE = 1'b0;
      RAWIN[4] = 1'b0; SMPL = 1'b1;
      tick();
      RAWIN[12] = 1'b0;
      tick();
      SMPL = 1'b0;
      n_tests++; if (HNDRPT !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_hndrpt got %b exp 1", HNDRPT); end
      #1 rst = 1'b1;
      model_reset();
      #1;
      n_tests++; if (HNDRPT !== 1'b0) begin n_fail++; $display("FAIL rmid_hndrpt got %b exp 0", HNDRPT); end
      n_tests++; if (PEND !== 3'b000) begin n_fail++; $display("FAIL rmid_pend got %b exp 000", PEND); end
      n_tests++; if (STABLE !== 24'hFFFFFF) begin n_fail++; $display("FAIL rmid_stable got %h exp %h", STABLE, 24'hFFFFFF); end
      #4 rst = 1'b0;
      SMPL = 1'b1;
      tick();
      n_tests++; if (STABLE[12] !== 1'b1) begin n_fail++; $display("FAIL rmid_recount got %b exp 1", STABLE[12]); end
      tick();
      SMPL = 1'b0;
      n_tests++; if (STABLE[12] !== 1'b0 || STABLE[4] !== 1'b0) begin n_fail++; $display("FAIL rmid_full_deb got %b%b exp 00", STABLE[12], STABLE[4]); end
      n_tests++; if (PEND !== 3'b000 || HNDRPT !== 1'b0) begin n_fail++; $display("FAIL rmid_no_event got pend %b hnd %b exp 000 0", PEND, HNDRPT); end
      restore_inputs();
   endtask

   task automatic test_random();
      int idx;
      int traps;
      traps = 0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) begin
            idx = $urandom_range(NB - 1);
            RAWIN[idx] = ~RAWIN[idx];
         end
         SMPL  = ($urandom_range(1) == 1);
         ARMWE = ($urandom_range(5) == 0);
         ARMD  = 3'($urandom);
         ACK   = ($urandom_range(7) == 0) ? 3'($urandom) : 3'b000;
         tick();
         if (m_hnd) traps++;
         n_tests++; if (STABLE !== m_stable) begin n_fail++; $display("FAIL rnd_stable c=%0d got %h exp %h", c, STABLE, m_stable); end
         n_tests++; if (ARMED !== m_armed) begin n_fail++; $display("FAIL rnd_armed c=%0d got %b exp %b", c, ARMED, m_armed); end
         n_tests++; if (PEND !== m_pend) begin n_fail++; $display("FAIL rnd_pend c=%0d got %b exp %b", c, PEND, m_pend); end
         n_tests++; if (HNDRPT !== m_hnd) begin n_fail++; $display("FAIL rnd_hndrpt c=%0d got %b exp %b", c, HNDRPT, m_hnd); end
      end
      ARMWE = 1'b0; ACK = '0; SMPL = 1'b0;
      $display("[TB] random phase saw %0d interrupt pulses", traps);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_debounce();
      test_armed_trap();
      test_unarmed_inactive();
      test_simultaneous();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hand_ctrl_trap.md
Name: hand_ctrl_trap

Overview:
- Parametrised successor to the fixed three-trap input logic (TRP31A/TRP31B/TRP32, HNDRPT) of the Inout II module.
- Debounces NGRP groups of GW discrete inputs, such as hand-controller, translation and mark inputs.
- Each group has a one-shot trap arm. A debounced transition to the active level in an armed group latches a pending flag, disarms that group and pulses HNDRPT to the interrupt priority chain.
- Adds what the old block lacks: N-sample debounce, an arbitrary group count and width, per-group pending status, and explicit acknowledge.

Parameters:
- NGRP, 3, number of trap groups.
- GW, 8, input bits per group.
- DEB, 2, consecutive differing samples required before a debounced bit changes (range 1..15).
- ACT_LOW, 1, inputs are active low, so an event is a 1->0 transition of a debounced bit; 0 selects active high.

Ports:
- CLOCK  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- SMPL  in  1  sample strobe, one CLOCK wide (F05-rate timing pulse).
- RAWIN  in  NGRP*GW  raw inputs; group g occupies bits [g*GW +: GW].
- ARMWE  in  1  arm-register write strobe (channel-13-style write).
- ARMD  in  NGRP  arm write data; 1 arms the group, 0 disarms it.
- ACK  in  NGRP  pending-clear mask, level-sampled every CLOCK.
- STABLE  out  NGRP*GW  debounced input values for channel read.
- ARMED  out  NGRP  current arm state.
- PEND  out  NGRP  trap pending per group.
- HNDRPT  out  1  interrupt request pulse.

Behaviour:
- Reset, asynchronous on rst high, applies immediately regardless of CLOCK, including mid-debounce or mid-pulse:
  - STABLE = all inactive (all 1s if ACT_LOW=1, else all 0s).
  - All debounce counters = 0.
  - ARMED = 0, PEND = 0, HNDRPT = 0.
  - No event is generated on reset release.
- All state is updated on the rising CLOCK edge.
- Debounce, per bit, on edges where SMPL=1:
  - If RAWIN != STABLE: counter increments. When the incremented value equals DEB, STABLE takes RAWIN and the counter clears to 0.
  - If RAWIN == STABLE: counter clears to 0 (a glitch restarts the count).
  - Counter width is clog2(DEB+1).
  - When SMPL=0, counters and STABLE hold.
- Latency: a raw change that holds across DEB consecutive strobes appears on STABLE at the edge of the DEB-th strobe.
- Event detection, per group: event[g] is true at the edge where any bit of group g changes STABLE value to the active level. Changes to the inactive level never create events.
- Trap, at the same edge as the STABLE update:
  - If event[g] and ARMED[g] (pre-edge value): PEND[g] <= 1 and ARMED[g] <= 0.
  - An event in an unarmed group is discarded and is not remembered for later.
- HNDRPT is registered. It is 1 for exactly one CLOCK after any edge at which at least one PEND bit went 0->1.
  - Several groups trapping at one edge produce a single pulse.
  - Traps at consecutive edges produce one pulse per edge.
- Arm write: on an edge with ARMWE=1, ARMED <= ARMD, except that a group trapping on that same edge ends disarmed. Trap disarm wins over the write.
- Acknowledge: PEND[g] clears on an edge with ACK[g]=1. If a trap sets PEND[g] on the same edge, set wins and HNDRPT still pulses.
- PEND[g] already 1 plus a new trap in g: PEND stays 1 and HNDRPT does not pulse (no 0->1 transition). In practice this cannot occur, because the group is disarmed after its first trap.
- Simultaneous events across groups are fully independent; there is no priority among groups.

Decomposition:
- Shared package holds:
  - function clog2.
  - localparam-style constants: INACTIVE_LVL derived from ACT_LOW, and the default NGRP/GW/DEB values.
- One sub-module, trap_debounce_bit: a single-bit debouncer with its counter, producing a stable output and a rise-to-active strobe. It is instantiated NGRP*GW times in a generate loop.
- Group OR-reduction, arm, pend and HNDRPT logic stay in the top module.

Test Plan:
- Reset then debounce: rst pulse with DEB=2, ACT_LOW=1. Expect STABLE=24'hFFFFFF, ARMED/PEND/HNDRPT=0. Drive RAWIN bit 3 to 0 for 2 strobes; STABLE[3]=0 at the 2nd strobe edge. Same test with a 1-strobe glitch: STABLE unchanged.
- Armed trap: ARMWE with ARMD=3'b001, then debounced 1->0 on bit 2. Expect PEND=3'b001, ARMED=3'b000 at that edge, HNDRPT high for exactly 1 CLOCK.
- Unarmed and inactive edges: ARMED=0, debounced 1->0 on bit 10, then a debounced 0->1 with group 1 armed. Expect PEND=0 and HNDRPT never asserted.
- Simultaneous traps: ARMED=3'b111, bits 0, 8 and 16 fall at the same strobe edge. Expect PEND=3'b111, ARMED=0, a single 1-cycle HNDRPT. Then ACK=3'b010: PEND=3'b101.
- Collisions: on the trap edge for group 2, also ARMWE with ARMD=3'b111 and ACK=3'b100. Expect ARMED=3'b011, PEND[2]=1, HNDRPT pulses.
- Reset mid-operation: assert rst asynchronously (not aligned to CLOCK) one CLOCK after a trap edge, while HNDRPT=1, with a debounce count pending. Expect immediate HNDRPT=0 and PEND=0. After release, the half-counted bit needs a full DEB strobes to change.
